// File: rtl/user_ram_ctrl.sv
// Native memory bus to single-port user RAM bridge.
// Full-word writes go direct; partial writes run a read-modify-write.
module user_ram_ctrl #(
    parameter int          ADDR_BIT  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0002_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mem_valid_i,
    input  logic [31:0]         mem_addr_i,
    input  logic [31:0]         mem_wdata_i,
    input  logic [3:0]          mem_wstrb_i,
    output logic                mem_ready_o,
    output logic [31:0]         mem_rdata_o,
    output logic                ram_wr_en_o,
    output logic                ram_rd_en_o,
    output logic [ADDR_BIT-1:0] ram_addr_o,
    output logic [31:0]         ram_di_o,
    input  logic [31:0]         ram_do_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RCAP,
        WR,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        rmw_q;
    logic        sel;
    logic [31:0] merge;
    logic        unused_addr_lsb;

    assign sel = mem_valid_i &&
                 (mem_addr_i[31:ADDR_BIT+2] == BASE_ADDR[31:ADDR_BIT+2]);

    assign unused_addr_lsb = ^mem_addr_i[1:0];

    // Strobed bytes come from the CPU, the rest from the word just read.
    always_comb begin
        merge = ram_do_i;
        for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) begin
                merge[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rmw_q       <= 1'b0;
            mem_ready_o <= 1'b0;
            mem_rdata_o <= '0;
            ram_wr_en_o <= 1'b0;
            ram_rd_en_o <= 1'b0;
            ram_addr_o  <= '0;
            ram_di_o    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    mem_ready_o <= 1'b0;
                    mem_rdata_o <= '0;
                    if (sel) begin
                        wdata_q    <= mem_wdata_i;
                        wstrb_q    <= mem_wstrb_i;
                        ram_addr_o <= mem_addr_i[ADDR_BIT+1:2];
                        if (mem_wstrb_i == 4'hF) begin
                            rmw_q       <= 1'b0;
                            ram_wr_en_o <= 1'b1;
                            ram_di_o    <= mem_wdata_i;
                            state       <= WR;
                        end else begin
                            rmw_q       <= (mem_wstrb_i != 4'h0);
                            ram_rd_en_o <= 1'b1;
                            state       <= RD;
                        end
                    end
                end
                RD: begin
                    // Hold rd_en so the RAM output stays valid for capture.
                    state <= RCAP;
                end
                RCAP: begin
                    ram_rd_en_o <= 1'b0;
                    if (rmw_q) begin
                        ram_wr_en_o <= 1'b1;
                        ram_di_o    <= merge;
                        state       <= WR;
                    end else begin
                        ram_addr_o  <= '0;
                        mem_ready_o <= 1'b1;
                        mem_rdata_o <= ram_do_i;
                        state       <= DONE;
                    end
                end
                WR: begin
                    ram_wr_en_o <= 1'b0;
                    ram_addr_o  <= '0;
                    ram_di_o    <= '0;
                    mem_ready_o <= 1'b1;
                    mem_rdata_o <= '0;
                    state       <= DONE;
                end
                DONE: begin
                    mem_ready_o <= 1'b0;
                    mem_rdata_o <= '0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_user_ram_ctrl.sv
// Scoreboard bench for user_ram_ctrl against a word-array reference.
// Driver pushes expectations; a negedge monitor pops and compares.
module tb_user_ram_ctrl;

    localparam logic [31:0] BASE = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        ram_wr;
    logic        ram_rd;
    logic [7:0]  ram_addr;
    logic [31:0] ram_di;
    logic [31:0] ram_do;

    user_ram_ctrl #(.ADDR_BIT(8), .BASE_ADDR(BASE)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mem_valid_i(mem_valid),
        .mem_addr_i (mem_addr),
        .mem_wdata_i(mem_wdata),
        .mem_wstrb_i(mem_wstrb),
        .mem_ready_o(mem_ready),
        .mem_rdata_o(mem_rdata),
        .ram_wr_en_o(ram_wr),
        .ram_rd_en_o(ram_rd),
        .ram_addr_o (ram_addr),
        .ram_di_o   (ram_di),
        .ram_do_i   (ram_do)
    );

    always #5 clk = ~clk;

    // Single-port RAM: output only meaningful while rd_en stays high.
    logic [31:0] ram [256];
    logic [31:0] ram_q = '0;
    always @(posedge clk) begin
        if (ram_rd) ram_q <= ram[ram_addr];
        if (ram_wr) ram[ram_addr] <= ram_di;
    end
    assign ram_do = ram_rd ? ram_q : 32'hA5A5_5A5A;

    typedef struct {
        int          start;
        int          lat;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wexp_t;

    exp_t        exp_q [$];
    wexp_t       wr_q [$];
    logic [31:0] ref_mem [256];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          mon_en = 1'b0;
    int          rd_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t  e;
            wexp_t w;
            chk(!(ram_wr && ram_rd) &&
                (ram_wr || ram_rd || ram_addr == 8'h0) &&
                (ram_wr || ram_di == 32'h0) &&
                (mem_ready || mem_rdata == 32'h0),
                "idle_zero_invariant",
                {ram_wr, ram_rd, mem_ready, 5'h0, ram_addr, 16'h0},
                32'h0);
            if (ram_rd) begin
                rd_run++;
            end else if (rd_run != 0) begin
                chk(rd_run == 2, "rd_en_len", 32'(rd_run), 32'd2);
                rd_run = 0;
            end
            if (mem_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(cyc - e.start == e.lat, "latency",
                        32'(cyc - e.start), 32'(e.lat));
                    chk(mem_rdata == e.rdata, "rdata", mem_rdata, e.rdata);
                end
            end
            if (ram_wr) begin
                if (wr_q.size() == 0) begin
                    chk(1'b0, "unexpected_write", {24'h0, ram_addr}, 32'h0);
                end else begin
                    w = wr_q.pop_front();
                    chk(ram_addr == w.a, "wr_addr", {24'h0, ram_addr}, {24'h0, w.a});
                    chk(ram_di == w.d, "wr_data", ram_di, w.d);
                end
            end
        end
    end

    // Issues one in-window request; returns at the negedge showing ready,
    // leaving valid high so the caller may chain the next request.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit scramble);
        exp_t        e;
        wexp_t       w;
        int          wi;
        bit          done;
        logic [31:0] m;
        wi = int'(a[9:2]);
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        e.start = cyc;
        if (s == 4'h0) begin
            e.lat   = 3;
            e.rdata = ref_mem[wi];
        end else begin
            m = ref_mem[wi];
            for (int b = 0; b < 4; b++)
                if (s[b]) m[8*b +: 8] = d[8*b +: 8];
            ref_mem[wi] = m;
            e.lat   = (s == 4'hF) ? 2 : 4;
            e.rdata = 32'h0;
            w.a = a[9:2];
            w.d = m;
            wr_q.push_back(w);
        end
        exp_q.push_back(e);
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (mem_ready) begin
                done = 1'b1;
            end else if (scramble && k >= 1) begin
                mem_addr  = $urandom;
                mem_wdata = $urandom;
                mem_wstrb = 4'($urandom);
                mem_valid = 1'($urandom_range(0, 1));
            end
        end
        if (!done) chk(1'b0, "ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic oow(input logic [31:0] a, input int n);
        bit quiet;
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom);
        quiet = 1'b1;
        repeat (n) begin
            @(negedge clk);
            if (mem_ready || ram_rd || ram_wr) quiet = 1'b0;
        end
        chk(quiet, "out_of_window_quiet", {31'h0, !quiet}, 32'h0);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
    endtask

    function automatic logic [31:0] win_addr(input int w);
        logic [31:0] a;
        a = BASE | (32'(w) << 2) | 32'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        int          r;
        int          w;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(!mem_ready && !ram_rd && !ram_wr && mem_rdata == 0 &&
            ram_addr == 0 && ram_di == 0, "reset_state",
            {ram_wr, ram_rd, mem_ready, 29'h0}, 32'h0);
        mon_en = 1'b1;

        do_req(32'h0002_0008, 32'hDEAD_BEEF, 4'hF, 1'b0);
        idle(1);
        do_req(32'h0002_0008, 32'h0, 4'h0, 1'b0);
        idle(1);
        do_req(32'h0002_0008, 32'h0000_5500, 4'b0010, 1'b0);
        idle(1);
        do_req(32'h0002_0008, 32'h0, 4'h0, 1'b0);
        idle(1);

        oow(32'h0002_0400, 10);
        oow(32'h0003_0000, 10);
        do_req(32'h0002_03FC, $urandom, 4'hF, 1'b0);
        idle(1);
        do_req(32'h0002_03FC, 32'h0, 4'h0, 1'b0);
        idle(2);

        // Partial write aborted by reset while capturing the old word.
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_addr  = 32'h0002_0010;
        mem_wdata = 32'h1234_5678;
        mem_wstrb = 4'b0100;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        mem_valid = 1'b0;
        @(negedge clk);
        chk(ram_rd && !ram_wr, "rcap_before_reset", {30'h0, ram_rd, ram_wr}, 32'h2);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(!mem_ready && !ram_rd && !ram_wr && ram_addr == 0,
            "post_reset_idle", {29'h0, mem_ready, ram_rd, ram_wr}, 32'h0);
        idle(4);
        do_req(32'h0002_0010, 32'hCAFE_F00D, 4'hF, 1'b0);
        idle(1);
        do_req(32'h0002_0010, 32'h0, 4'h0, 1'b0);

        do_req(32'h0002_0020, 32'h0BAD_C0DE, 4'hF, 1'b0);
        do_req(32'h0002_0020, 32'h0, 4'h0, 1'b0);
        idle(1);

        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                a = $urandom;
                for (int g = 0; g < 8 && a[31:10] == 22'h80; g++) a = $urandom;
                if (a[31:10] == 22'h80) a = 32'h0004_0000;
                oow(a, 3);
            end else begin
                w = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7)
                                                : $urandom_range(0, 255);
                r = $urandom_range(0, 9);
                if (r < 4)      s = 4'h0;
                else if (r < 7) s = 4'hF;
                else            s = 4'($urandom_range(1, 14));
                do_req(win_addr(w), $urandom, s, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
            end
        end
        idle(6);
        chk(exp_q.size() == 0 && wr_q.size() == 0, "queues_drained",
            32'(exp_q.size() + wr_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
